// File: rtl/fir_sample_feeder_if.sv
// fir_sample_feeder_if: valid/ready sample stream from the feeder to the FIR input.
//   valid - head sample is available (driven by the feeder)
//   data  - head sample, signed two's complement (driven by the feeder)
//   ready - FIR accepts the head sample (driven by the FIR)
// A transfer happens on every clock edge where valid && ready.
interface fir_sample_feeder_if #(
   parameter int unsigned SAMP_WIDTH = 24
);
   logic                  valid;
   logic                  ready;
   logic [SAMP_WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: sample-rate front end ahead of the FIR low-pass filter.
// Decimates the free-running generator output with a programmable divider, adds an
// arithmetically shifted noise sample to the clean sample, buffers the result in a small
// FIFO and hands it to the FIR over a valid/ready stream. Samples lost to a full FIFO are
// counted (saturating).
//
// Build option: define FIR_FEEDER_SAT_EN to saturate the mixed sum; without it the sum
// wraps in two's complement and no clamp logic is built.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_en            divider enable; low holds the divider at 0 (pipeline and FIFO still drain)
//   i_rate_div      strobe period minus one, in clock cycles
//   i_sig, i_noise  clean and noise samples, signed
//   i_noise_shift   arithmetic right shift applied to i_noise (0..3)
//   fir             output stream (master): valid/data out, ready in
//   o_fifo_lvl      current FIFO occupancy
//   o_drop_cnt      samples discarded because the FIFO was full, saturating
module fir_sample_feeder #(
   parameter int unsigned SAMP_WIDTH = 24,
   parameter int unsigned FIFO_DEPTH = 4,   // power of two, >= 2
   parameter int unsigned DROP_WIDTH = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_en,
   input  logic [15:0]                   i_rate_div,
   input  logic [SAMP_WIDTH-1:0]         i_sig,
   input  logic [SAMP_WIDTH-1:0]         i_noise,
   input  logic [1:0]                    i_noise_shift,
   fir_sample_feeder_if.master           fir,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_lvl,
   output logic [DROP_WIDTH-1:0]         o_drop_cnt
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   // ---------------------------------------------------------------- divider
   logic [15:0] div_q, div_d;
   logic        strobe;

   assign strobe = i_en && (div_q == i_rate_div);

   always_comb begin
      div_d = div_q + 16'd1;   // wraps through 0xFFFF if i_rate_div drops below the count
      if (!i_en || strobe) begin
         div_d = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   // ---------------------------------------------------------------- capture stage
   logic                         s1_valid_q;
   logic signed [SAMP_WIDTH-1:0] s1_sig_q;
   logic signed [SAMP_WIDTH-1:0] s1_noise_q;
   logic [1:0]                   s1_shift_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sig_q   <= '0;
         s1_noise_q <= '0;
         s1_shift_q <= '0;
      end else begin
         s1_valid_q <= strobe;
         if (strobe) begin
            s1_sig_q   <= i_sig;
            s1_noise_q <= i_noise;
            s1_shift_q <= i_noise_shift;
         end
      end
   end

   // ---------------------------------------------------------------- mix stage
   logic signed [SAMP_WIDTH-1:0] noise_sh;
   logic        [SAMP_WIDTH-1:0] mix;
   logic                         s2_valid_q;
   logic        [SAMP_WIDTH-1:0] s2_data_q;

   assign noise_sh = s1_noise_q >>> s1_shift_q;

`ifdef FIR_FEEDER_SAT_EN
   logic [SAMP_WIDTH:0] sum_wide;

   always_comb begin
      sum_wide = {s1_sig_q[SAMP_WIDTH-1], s1_sig_q} + {noise_sh[SAMP_WIDTH-1], noise_sh};
      // The two top bits differ only when the sum left the SAMP_WIDTH range.
      if (sum_wide[SAMP_WIDTH] != sum_wide[SAMP_WIDTH-1]) begin
         mix = sum_wide[SAMP_WIDTH] ? {1'b1, {(SAMP_WIDTH-1){1'b0}}}
                                    : {1'b0, {(SAMP_WIDTH-1){1'b1}}};
      end else begin
         mix = sum_wide[SAMP_WIDTH-1:0];
      end
   end
`else
   assign mix = s1_sig_q + noise_sh;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
      end else begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_data_q <= mix;
         end
      end
   end

   // ---------------------------------------------------------------- output FIFO
   logic [SAMP_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]      lvl_q, lvl_d;
   logic [DROP_WIDTH-1:0] drop_cnt_q;
   logic                  full, pop, push_ok, drop;

   assign full    = (lvl_q == LVL_FULL);
   assign pop     = fir.valid && fir.ready;
   // A full FIFO still takes the sample when the head leaves in the same cycle.
   assign push_ok = s2_valid_q && (!full || pop);
   assign drop    = s2_valid_q && full && !pop;

   always_comb begin
      lvl_d = lvl_q;
      unique case ({push_ok, pop})
         2'b10:   lvl_d = lvl_q + LVL_W'(1);
         2'b01:   lvl_d = lvl_q - LVL_W'(1);
         default: lvl_d = lvl_q;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         lvl_q      <= '0;
         drop_cnt_q <= '0;
      end else begin
         lvl_q <= lvl_d;
         if (push_ok) begin
            mem_q[wr_ptr_q] <= s2_data_q;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + DROP_WIDTH'(1);
         end
      end
   end

   assign fir.valid  = (lvl_q != '0);
   assign fir.data   = mem_q[rd_ptr_q];
   assign o_fifo_lvl = lvl_q;
   assign o_drop_cnt = drop_cnt_q;

endmodule

// File: doc/fir_sample_feeder.md
# fir_sample_feeder

Sample-rate front end between the test-signal generator and the FIR low-pass filter. It decimates the generator's free-running output to a programmable sample rate and adds an attenuated noise sample to a clean signal sample. The sum is saturated, buffered in a small FIFO and presented to the FIR input through a valid/ready handshake. Overflow drops are counted so the bench and the on-chip monitor can detect FIR back-pressure.

## Interface

Parameters:
- SAMP_WIDTH, 24: signed sample width of inputs and output.
- FIFO_DEPTH, 4: output FIFO entries. Must be a power of two, ≥2.
- DROP_WIDTH, 16: drop counter width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_en  in  1  strobe enable. Low holds the divider at 0.
- i_rate_div  in  16  strobe period minus one, in clock cycles.
- i_sig  in  SAMP_WIDTH  clean sample, signed two's complement.
- i_noise  in  SAMP_WIDTH  noise sample from the generator, signed.
- i_noise_shift  in  2  arithmetic right-shift applied to i_noise (0..3).
- i_ready  in  1  FIR accepts the head sample.
- o_valid  out  1  FIFO not empty.
- o_data  out  SAMP_WIDTH  FIFO head sample.
- o_fifo_lvl  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_drop_cnt  out  DROP_WIDTH  samples lost to a full FIFO. Saturates at all-ones.

## Operation

- **Divider**
  - 16-bit counter, cleared to 0 while i_en=0.
  - Strobe asserts in the cycle where count==i_rate_div; the counter returns to 0 on the next edge, otherwise it increments.
  - i_rate_div=0 gives a strobe every cycle.
  - If i_rate_div changes to a value below the current count, the counter runs up and wraps through 0xFFFF. No special handling.
- **Capture stage (S1)**
  - On a strobe edge, register i_sig, i_noise and i_noise_shift.
  - Set the s1_valid flag; otherwise clear it.
- **Mix stage (S2)**
  - Sum = sign-extend(sig) + (noise >>> shift), computed in SAMP_WIDTH+1 bits.
  - Result is reduced to SAMP_WIDTH bits per the Configuration section.
  - Registered with s2_valid = s1_valid of the previous cycle.
- **FIFO**
  - Push when s2_valid=1. Pop when o_valid && i_ready.
  - Full with push and no pop: the sample is discarded, o_drop_cnt increments (saturating), and FIFO contents are unchanged.
  - Full with push and pop in the same cycle: both are performed, no drop, level unchanged.
  - Empty with push: level becomes 1. o_data and o_valid update after the edge; there is no same-cycle bypass.
  - Pop while empty cannot occur, because o_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
  - o_data is the head entry and is stable while o_valid=1 and i_ready=0.
- **i_en deassertion**
  - No new strobes are generated.
  - Samples already in S1/S2 complete and are pushed.
  - The FIFO continues to drain.

## Timing

- **Reset values:** o_valid=0, o_data=0, o_fifo_lvl=0, o_drop_cnt=0. Divider, S1, S2 and all FIFO storage are 0.
- **Reset mid-operation:** all state clears immediately (asynchronous). In-flight samples are lost and not counted as drops.
- **Latency, empty FIFO:**
  - Strobe in cycle N; S1 loads at the end of N.
  - S2 loads at the end of N+1.
  - FIFO write at the end of N+2.
  - o_valid=1 in cycle N+3.
- **Throughput:** one sample per cycle sustained when i_rate_div=0 and i_ready=1.
- **Handshake:** a transfer occurs on every edge where o_valid && i_ready. o_valid never drops without a pop.

## Configuration

Macro FIR_FEEDER_SAT_EN selects how the mix-stage sum is reduced to SAMP_WIDTH bits.
- **Defined:** the sum saturates.
  - Values above 2^(SAMP_WIDTH-1)-1 clamp to 0x7FFFFF (for 24 bits).
  - Values below -2^(SAMP_WIDTH-1) clamp to 0x800000.
- **Undefined:** the low SAMP_WIDTH bits of the sum are taken, giving two's-complement wrap. No extra logic is built.

## Test plan

- **Latency and basic sum**
  - Stimulus: i_rate_div=3, i_en=1, i_sig=0x000100, i_noise=0x000040, shift=1, i_ready=1.
  - Required: o_valid pulses 1 cycle per 4 cycles, o_data=0x000120, first o_valid 3 cycles after the first strobe.
- **Saturation / wrap**
  - Stimulus: i_sig=0x7FFFF0, i_noise=0x000100, shift=0.
  - Required: o_data=0x7FFFFF with FIR_FEEDER_SAT_EN defined, 0x8000F0 without it.
  - Negative case: i_sig=0x800010, i_noise=0xFFFF00 gives 0x800000 saturated and 0x7FFF10 wrapped.
- **Back-pressure and drops**
  - Stimulus: i_rate_div=0, i_ready=0 for 10 strobes.
  - Required: o_fifo_lvl=4, o_drop_cnt=6, and o_data equals the first sample throughout.
- **Full with simultaneous push and pop**
  - Stimulus: FIFO full, then i_ready=1 with continuous strobes.
  - Required: o_fifo_lvl stays 4, o_drop_cnt does not change, samples emerge in order.
- **Drop counter saturation**
  - Stimulus: DROP_WIDTH=4, i_ready=0, 25 strobes.
  - Required: o_drop_cnt=0xF.
- **Enable and reset mid-stream**
  - Stimulus: deassert i_en one cycle after a strobe.
  - Required: that sample still appears at o_data, with no further samples.
  - Then assert i_rst_n=0 mid-stream. Required: o_valid=0, o_fifo_lvl=0 and o_drop_cnt=0 asynchronously.
